// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - four-requester round-robin arbiter with hold timeout, one-hot registered grant
// Optional build macro ARB_LOCK_EN adds a lock input that suppresses the hold timeout.
module rr_arbiter4 #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
`ifdef ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             valid_q, valid_d;

  logic [2:0] idle_pick, hand_pick;
  logic [3:0] others;
  logic       lock_act, timeout;

  // Returns {found, index} of the first set bit scanning from p+1 upward with wrap.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] i;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      i = p + 2'(k);
      if (r[i]) res = {1'b1, i};
    end
    return res;
  endfunction

  always_comb begin
`ifdef ARB_LOCK_EN
    lock_act = lock & valid_q;
`else
    lock_act = 1'b0;
`endif
    others    = req & ~(4'(1) << idx_q);
    idle_pick = rr_pick(req, ptr_q);
    hand_pick = rr_pick(others, idx_q);
    timeout   = (hold_q == HOLD_LAST) && (|others) && !lock_act;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (!en) begin
      state_d = IDLE;
      gnt_d   = 4'b0000;
      valid_d = 1'b0;
      hold_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (idle_pick[2]) begin
            state_d = GRANT;
            idx_d   = idle_pick[1:0];
            ptr_d   = idle_pick[1:0];
            gnt_d   = 4'(1) << idle_pick[1:0];
            valid_d = 1'b1;
            hold_d  = '0;
          end
        end
        GRANT: begin
          // Release takes precedence; both paths hand over to the next requester after the holder.
          if (!req[idx_q] || timeout) begin
            hold_d = '0;
            if (hand_pick[2]) begin
              idx_d = hand_pick[1:0];
              ptr_d = hand_pick[1:0];
              gnt_d = 4'(1) << hand_pick[1:0];
            end else begin
              state_d = IDLE;
              gnt_d   = 4'b0000;
              valid_d = 1'b0;
            end
          end else if (hold_q != HOLD_LAST) begin
            hold_d = hold_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'b11;
      hold_q  <= '0;
      gnt_q   <= 4'b0000;
      idx_q   <= 2'b00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb/tb_rr_arbiter4.sv - scoreboard bench for rr_arbiter4 against an ownership-level reference model
module tb_rr_arbiter4;
  localparam int HOLD_MAX = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       lock_s = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;

  rr_arbiter4 #(.HOLD_MAX(HOLD_MAX), .CNT_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .req(req),
`ifdef ARB_LOCK_EN
    .lock(lock_s),
`endif
    .gnt(gnt),
    .gnt_idx(gnt_idx),
    .gnt_valid(gnt_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] g;
    int         owner;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   stim_done = 0;

  // Reference model state: who owns the resource, last owner, and how long it has owned it.
  int m_owner = -1;
  int m_ptr = 3;
  int m_held = 0;

  function automatic int first_from(input logic [3:0] r, input int p, input int excl);
    for (int k = 1; k <= 4; k++) begin
      int j;
      j = (p + k) % 4;
      if (j != excl && r[j]) return j;
    end
    return -1;
  endfunction

  function automatic void model_step(input bit rst, input bit e, input logic [3:0] r, input bit lk);
    int  w;
    bit  others;
    if (rst) begin
      m_owner = -1; m_ptr = 3; m_held = 0;
    end else if (!e) begin
      m_owner = -1; m_held = 0;
    end else if (m_owner < 0) begin
      w = first_from(r, m_ptr, -1);
      if (w >= 0) begin m_owner = w; m_ptr = w; m_held = 1; end
    end else begin
      others = 0;
      for (int j = 0; j < 4; j++) if (j != m_owner && r[j]) others = 1;
      if (!r[m_owner] || (m_held >= HOLD_MAX && others && !lk)) begin
        w = first_from(r, m_owner, m_owner);
        if (w >= 0) begin m_owner = w; m_ptr = w; m_held = 1; end
        else begin m_owner = -1; m_held = 0; end
      end else begin
        m_held++;
      end
    end
  endfunction

  task automatic step(input bit rst, input bit e, input logic [3:0] r, input bit lk);
    exp_t x;
    @(negedge clk);
    rst_n = !rst; en = e; req = r; lock_s = lk;
`ifdef ARB_LOCK_EN
    model_step(rst, e, r, lk);
`else
    model_step(rst, e, r, 1'b0);
`endif
    x.owner = m_owner;
    x.g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    exp_q.push_back(x);
  endtask

  // Monitor: every edge produces a registered output, compared against the oldest expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        n_checks++;
        if (gnt !== x.g) begin
          n_fail++;
          $display("FAIL gnt t=%0t actual=%b required=%b", $time, gnt, x.g);
        end
        n_checks++;
        if (gnt_valid !== (x.owner >= 0)) begin
          n_fail++;
          $display("FAIL gnt_valid t=%0t actual=%b required=%b", $time, gnt_valid, (x.owner >= 0));
        end
        if (x.owner >= 0) begin
          n_checks++;
          if (gnt_idx !== 2'(x.owner)) begin
            n_fail++;
            $display("FAIL gnt_idx t=%0t actual=%0d required=%0d", $time, gnt_idx, x.owner);
          end
        end
        n_checks++;
        if ($countones(gnt) > 1) begin
          n_fail++;
          $display("FAIL onehot t=%0t actual=%b required=at most one bit", $time, gnt);
        end
      end
    end
  end

  initial begin
    logic [3:0] r;
    bit         e, lk;
    // Reset then single request
    step(1, 1, 4'b1111, 0);
    step(1, 0, 4'b0000, 0);
    step(0, 1, 4'b0100, 0);
    step(0, 1, 4'b0100, 0);
    step(0, 1, 4'b0000, 0);
    // Rotation with everyone requesting
    step(1, 0, 4'b0000, 0);
    for (int i = 0; i < 40; i++) step(0, 1, 4'b1111, 0);
    // Release hand-off from holder 1
    step(1, 0, 4'b0000, 0);
    step(0, 1, 4'b0010, 0);
    step(0, 1, 4'b1011, 0);
    step(0, 1, 4'b1001, 0);
    step(0, 1, 4'b1001, 0);
    // Lone holder then release to idle
    step(0, 1, 4'b0000, 0);
    for (int i = 0; i < 50; i++) step(0, 1, 4'b0001, 0);
    step(0, 1, 4'b0000, 0);
    step(0, 1, 4'b0000, 0);
    // Enable drop while index 2 holds, then re-enable
    step(0, 1, 4'b0100, 0);
    step(0, 1, 4'b0100, 0);
    step(0, 0, 4'b0100, 0);
    step(0, 1, 4'b0101, 0);
    step(0, 1, 4'b0101, 0);
    // Lock holds the grant past the timeout, unlock hands over at once
    step(0, 1, 4'b0000, 0);
    step(1, 0, 4'b0000, 0);
    step(0, 1, 4'b0011, 1);
    for (int i = 0; i < 20; i++) step(0, 1, 4'b0011, 1);
    step(0, 1, 4'b0011, 0);
    step(0, 1, 4'b0011, 0);
    // Randomized traffic with sticky requests so holds and timeouts occur
    r = 4'b0000; e = 1; lk = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) r = 4'($urandom_range(0, 15));
      e = ($urandom_range(0, 40) != 0);
      if ($urandom_range(0, 15) == 0) lk = !lk;
      step($urandom_range(0, 300) == 0, e, r, lk);
    end
    stim_done = 1;
  end

  initial begin
    int guard;
    guard = 0;
    while (!stim_done && guard < 50000) begin
      @(posedge clk);
      guard++;
    end
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (!stim_done || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d pending done=%0d required=0 pending done=1", exp_q.size(), stim_done);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
